fetch_trace_buf: RTL and testbench
==================================

FETCH_TRACE_BUF -- requirements
Module: fetch_trace_buf

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- LANES, 2, fetch lanes observed per cycle (1..4)
- DEPTH, 16, trace entries (power of two, >=2)
- PC_W, 64, PC width
- INST_W, 32, instruction width
- SEQ_W, 16, sequence tag width

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush
- cap_en  in  1  capture enable
- f_valid  in  LANES  per-lane fetch valid
- f_pc  in  LANES*PC_W  packed PCs, lane 0 in LSBs
- f_inst  in  LANES*INST_W  packed instructions, lane 0 in LSBs
- rd_valid  out  1  head entry available
- rd_ready  in  1  consumer accepts head
- rd_pc  out  PC_W  head PC
- rd_inst  out  INST_W  head instruction
- rd_lane  out  $clog2(LANES) (min 1)  head source lane
- rd_seq  out  SEQ_W  head sequence tag
- count  out  $clog2(DEPTH+1)  occupancy
- drop_cnt  out  16  dropped-entry count

Function
REQ-003 An offered entry SHALL be each lane i with f_valid[i]=1 in a cycle with cap_en=1; lanes with cap_en=0 SHALL be ignored, neither stored nor counted.
REQ-004 Offered entries SHALL be processed in ascending lane order; lanes need not be contiguous, and only valid lanes consume slots.
REQ-005 Free space SHALL be DEPTH-count, plus 1 if a pop (rd_valid&&rd_ready) occurs in the same cycle.
REQ-006 Offered entries SHALL be accepted in lane order until free space is exhausted; the remaining offered entries that cycle SHALL be dropped.
REQ-007 drop_cnt SHALL increment by the number of dropped entries and saturate at 0xFFFF.
REQ-008 Every offered entry, accepted or dropped, SHALL receive the next sequence value, starting at 0 and incrementing modulo 2^SEQ_W, so that gaps in rd_seq expose drops.
REQ-009 An accepted entry SHALL store {pc, inst, lane, seq} and SHALL be visible at the head no earlier than the cycle after the capturing edge (1-cycle latency).
REQ-010 rd_valid SHALL be (count!=0); rd_* outputs SHALL show the oldest entry (show-ahead) and SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-011 A pop SHALL occur only when rd_valid&&rd_ready; rd_ready with rd_valid=0 SHALL have no effect.
REQ-012 count SHALL update as count + accepted - pop each cycle and SHALL never exceed DEPTH.
REQ-013 Read and write pointers SHALL wrap modulo DEPTH.
REQ-014 clr=1 SHALL have priority over all other activity in its cycle and SHALL empty the buffer and zero drop_cnt and the sequence counter; any push or pop in that cycle SHALL be discarded.

Reset
REQ-015 While rst_n=0, the block SHALL asynchronously set count=0, rd_valid=0, drop_cnt=0, sequence counter=0, pointers=0, and rd_pc/rd_inst/rd_lane/rd_seq=0.
REQ-016 Reset mid-operation SHALL discard all stored entries; the first offered entry after reset release SHALL get seq 0.

Configuration
REQ-017 When FETCH_TRACE_DISPLAY_EN is defined, the block SHALL $display one line per accepted entry at the capturing edge: $time, "Fetch[<lane>]: [%08x] %x" (pc, inst).
REQ-018 When FETCH_TRACE_DISPLAY_EN is defined, the block SHALL $display one line per cycle with drops, giving the number dropped.
REQ-019 Without FETCH_TRACE_DISPLAY_EN, no display code SHALL be compiled, and cycle behaviour SHALL be identical in both builds.

Verification (LANES=2, DEPTH=4)
REQ-020 Hold rst_n=0 -> rd_valid=0, count=0, drop_cnt=0, rd_pc=0.
REQ-021 Offer lane0 pc=0x80000000, inst=0x00000013, with rd_ready=0 -> next cycle rd_valid=1, rd_pc=0x80000000, rd_lane=0, rd_seq=0, count=1.
REQ-022 Offer both lanes for 3 cycles with rd_ready=0 -> count=4, drop_cnt=2, head seqs 0,1,2,3; next offered entry gets seq 6.
REQ-023 With count=4, rd_ready=1, and both lanes offered -> lane0 accepted, lane1 dropped, count stays 4, drop_cnt +1.
REQ-024 Assert clr together with a 2-lane offer and rd_ready=1 while count=3 -> next cycle count=0, drop_cnt=0, rd_valid=0; next offered entry gets seq 0.
REQ-025 With FETCH_TRACE_DISPLAY_EN defined, offer only lane1 valid -> exactly one "Fetch[1]" line; without the macro, zero lines and an identical waveform.

Source files
------------

// File: rtl/fetch_trace_buf.sv
// -----------------------------------------------------------------------------
// fetch_trace_buf
//   Captures up to LANES fetched instructions per cycle into a DEPTH-entry
//   trace FIFO. Each offered entry gets a running sequence tag, so a consumer
//   can spot dropped entries as gaps in rd_seq. When the buffer cannot take
//   every offered entry, the lowest lanes win and the rest are dropped and
//   counted in a saturating 16-bit counter. The read side is show-ahead.
//
// Optional feature:
//   FETCH_TRACE_DISPLAY_EN  when defined, prints one line per accepted entry
//                           and one line per cycle that drops entries.
//                           Cycle behaviour is the same in both builds.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous flush; wins over push and pop in its cycle
//   cap_en          capture enable for all lanes
//   f_valid         per-lane fetch valid
//   f_pc, f_inst    packed per-lane PC / instruction, lane 0 in the LSBs
//   rd_valid        head entry available (count != 0)
//   rd_ready        consumer accepts head
//   rd_pc, rd_inst, rd_lane, rd_seq   head entry fields
//   count           occupancy
//   drop_cnt        saturating count of dropped entries
// -----------------------------------------------------------------------------
module fetch_trace_buf #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 16,
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int SEQ_W  = 16,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      cap_en,
  input  logic [LANES-1:0]          f_valid,
  input  logic [LANES*PC_W-1:0]     f_pc,
  input  logic [LANES*INST_W-1:0]   f_inst,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [PC_W-1:0]           rd_pc,
  output logic [INST_W-1:0]         rd_inst,
  output logic [LANE_W-1:0]         rd_lane,
  output logic [SEQ_W-1:0]          rd_seq,
  output logic [CNT_W-1:0]          count,
  output logic [15:0]               drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  // One extra bit so DEPTH+1 free slots and small lane sums never overflow.
  localparam int SUM_W = CNT_W + 1;

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [LANE_W-1:0] mem_lane [DEPTH];
  logic [SEQ_W-1:0]  mem_seq  [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [SEQ_W-1:0]  seq_cnt;

  logic              pop;
  logic [SUM_W-1:0]  free_slots;
  logic [SUM_W-1:0]  acc_n;
  logic [SUM_W-1:0]  off_n;
  logic [SUM_W-1:0]  drop_n;
  logic [16:0]       drop_sum;
  logic [LANES-1:0]  lane_acc;
  logic [PTR_W-1:0]  lane_slot [LANES];
  logic [SEQ_W-1:0]  lane_seq  [LANES];

  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready && !clr;

  // Walk the lanes in ascending order: every offered lane takes the next
  // sequence tag, and the first free_slots offered lanes are accepted into
  // consecutive write slots.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    free_slots = SUM_W'(DEPTH) - SUM_W'(count) + SUM_W'(pop);
    acc_n      = '0;
    off_n      = '0;
    drop_n     = '0;
    lane_acc   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_slot[i] = '0;
      lane_seq[i]  = '0;
      if (cap_en && f_valid[i]) begin
        lane_seq[i] = seq_cnt + SEQ_W'(off_n);
        if (acc_n < free_slots) begin
          lane_acc[i]  = !clr;
          lane_slot[i] = wr_ptr + PTR_W'(acc_n);
          acc_n        = acc_n + SUM_W'(1);
        end else begin
          drop_n = drop_n + SUM_W'(1);
        end
        off_n = off_n + SUM_W'(1);
      end
    end
    drop_sum = {1'b0, drop_cnt} + 17'(drop_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      seq_cnt  <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      seq_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      // Power-of-two DEPTH: pointers wrap by natural overflow.
      rd_ptr   <= rd_ptr + PTR_W'(pop);
      wr_ptr   <= wr_ptr + PTR_W'(acc_n);
      count    <= CNT_W'(SUM_W'(count) + acc_n - SUM_W'(pop));
      seq_cnt  <= seq_cnt + SEQ_W'(off_n);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // NOTE: the entry storage has no reset; stale contents are unreachable
  // because the pointers and count are reset, and the read mux masks them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_acc[i]) begin
        mem_pc[lane_slot[i]]   <= f_pc[i*PC_W +: PC_W];
        mem_inst[lane_slot[i]] <= f_inst[i*INST_W +: INST_W];
        mem_lane[lane_slot[i]] <= LANE_W'(i);
        mem_seq[lane_slot[i]]  <= lane_seq[i];
      end
    end
  end

  // Show-ahead head; forced to zero while empty so reset reads as all zeros.
  assign rd_pc   = rd_valid ? mem_pc[rd_ptr]   : '0;
  assign rd_inst = rd_valid ? mem_inst[rd_ptr] : '0;
  assign rd_lane = rd_valid ? mem_lane[rd_ptr] : '0;
  assign rd_seq  = rd_valid ? mem_seq[rd_ptr]  : '0;

`ifdef FETCH_TRACE_DISPLAY_EN
  always @(posedge clk) begin
    if (rst_n && !clr) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_acc[i])
          $display("%0t Fetch[%0d]: [%08x] %x", $time, i,
                   f_pc[i*PC_W +: PC_W], f_inst[i*INST_W +: INST_W]);
      end
      if (drop_n != '0)
        $display("%0t Fetch: %0d entries dropped", $time, drop_n);
    end
  end
`else
`endif

endmodule

// File: tb/tb_fetch_trace_buf.sv
// -----------------------------------------------------------------------------
// tb_fetch_trace_buf
//   Self-checking bench for fetch_trace_buf (LANES=2, DEPTH=4). A queue-based
//   model tracks the buffer contents, the sequence counter and the drop count;
//   the DUT is compared against it every cycle, and a few hand-derived literal
//   values pin the model on the directed scenarios.
// -----------------------------------------------------------------------------
module tb_fetch_trace_buf;

  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clr;
  logic                 cap_en;
  logic [LANES-1:0]     f_valid;
  logic [LANES*64-1:0]  f_pc;
  logic [LANES*32-1:0]  f_inst;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [63:0]          rd_pc;
  logic [31:0]          rd_inst;
  logic [0:0]           rd_lane;
  logic [15:0]          rd_seq;
  logic [2:0]           count;
  logic [15:0]          drop_cnt;

  fetch_trace_buf #(
    .LANES(LANES), .DEPTH(DEPTH), .PC_W(64), .INST_W(32), .SEQ_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cap_en(cap_en),
    .f_valid(f_valid), .f_pc(f_pc), .f_inst(f_inst),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_lane(rd_lane), .rd_seq(rd_seq),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    int          lane;
    int          seq;
  } ent_t;

  ent_t q[$];
  int   m_seq;
  int   m_drop;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, from the inputs currently driven.
  task automatic model_step();
    int   fr;
    int   acc;
    ent_t e;
    if (clr) begin
      q.delete();
      m_seq  = 0;
      m_drop = 0;
    end else begin
      fr  = DEPTH - q.size();
      acc = 0;
      if (rd_ready && q.size() > 0) begin
        void'(q.pop_front());
        fr++;
      end
      for (int i = 0; i < LANES; i++) begin
        if (cap_en && f_valid[i]) begin
          if (acc < fr) begin
            e.pc   = f_pc[i*64 +: 64];
            e.inst = f_inst[i*32 +: 32];
            e.lane = i;
            e.seq  = m_seq;
            q.push_back(e);
            acc++;
          end else if (m_drop < 65535) begin
            m_drop++;
          end
          m_seq = (m_seq + 1) % 65536;
        end
      end
    end
  endtask

  task automatic compare_model();
    check("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
    check("count", 64'(count), 64'(q.size()));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (q.size() != 0) begin
      check("rd_pc", rd_pc, q[0].pc);
      check("rd_inst", 64'(rd_inst), 64'(q[0].inst));
      check("rd_lane", 64'(rd_lane), 64'(q[0].lane));
      check("rd_seq", 64'(rd_seq), 64'(q[0].seq));
    end
  endtask

  // Called at a falling edge: drive inputs, advance the model, clock once,
  // then compare at the next falling edge.
  task automatic drive(input logic c_en, input logic [1:0] v,
                       input logic [63:0] p0, input logic [63:0] p1,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic rdy, input logic cl);
    cap_en   = c_en;
    f_valid  = v;
    f_pc     = {p1, p0};
    f_inst   = {i1, i0};
    rd_ready = rdy;
    clr      = cl;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive_rand(input bit allow_clr);
    drive($urandom_range(0, 7) != 0, 2'($urandom), {$urandom, $urandom},
          {$urandom, $urandom}, $urandom, $urandom,
          $urandom_range(0, 2) != 0, allow_clr && ($urandom_range(0, 63) == 0));
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    m_seq  = 0;
    m_drop = 0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_model();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    cap_en   = 1'b0;
    f_valid  = '0;
    f_pc     = '0;
    f_inst   = '0;
    rd_ready = 1'b0;
    m_seq    = 0;
    m_drop   = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset rd_valid", 64'(rd_valid), 64'd0);
    check("reset count", 64'(count), 64'd0);
    check("reset drop_cnt", 64'(drop_cnt), 64'd0);
    check("reset rd_pc", rd_pc, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First capture: single lane, one-cycle latency.
    drive(1, 2'b01, 64'h8000_0000, 64'h0, 32'h0000_0013, 32'h0, 0, 0);
    check("first rd_valid", 64'(rd_valid), 64'd1);
    check("first rd_pc", rd_pc, 64'h8000_0000);
    check("first rd_lane", 64'(rd_lane), 64'd0);
    check("first rd_seq", 64'(rd_seq), 64'd0);
    check("first count", 64'(count), 64'd1);

    // Fill from empty: 6 offered, 4 kept (seq 0..3), 2 dropped (seq 4,5).
    drive(0, 2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 0, 1);
    check("clr count", 64'(count), 64'd0);
    for (int c = 0; c < 3; c++)
      drive(1, 2'b11, 64'h1000 + 64'(8*c), 64'h1004 + 64'(8*c),
            32'h100 + 32'(c), 32'h200 + 32'(c), 0, 0);
    check("fill count", 64'(count), 64'd4);
    check("fill drop_cnt", 64'(drop_cnt), 64'd2);
    check("fill head seq", 64'(rd_seq), 64'd0);

    // Full with a pop: lane0 accepted (seq 6), lane1 dropped (seq 7).
    drive(1, 2'b11, 64'h2000, 64'h2004, 32'h300, 32'h301, 1, 0);
    check("full-pop count", 64'(count), 64'd4);
    check("full-pop drop_cnt", 64'(drop_cnt), 64'd3);
    check("full-pop head seq", 64'(rd_seq), 64'd1);
    drive(0, 2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 1, 0);
    check("head seq 2", 64'(rd_seq), 64'd2);
    drive(0, 2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 1, 0);
    check("head seq 3", 64'(rd_seq), 64'd3);
    drive(0, 2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 1, 0);
    check("head seq 6", 64'(rd_seq), 64'd6);
    check("head pc lane0", rd_pc, 64'h2000);
    drive(1, 2'b11, 64'h3000, 64'h3004, 32'h400, 32'h401, 0, 0);
    check("pre-clr count", 64'(count), 64'd3);

    // Clear wins over a simultaneous push and pop.
    drive(1, 2'b11, 64'h4000, 64'h4004, 32'h500, 32'h501, 1, 1);
    check("clr2 count", 64'(count), 64'd0);
    check("clr2 drop_cnt", 64'(drop_cnt), 64'd0);
    check("clr2 rd_valid", 64'(rd_valid), 64'd0);
    drive(1, 2'b10, 64'h0, 64'h5004, 32'h0, 32'h601, 0, 0);
    check("post-clr seq", 64'(rd_seq), 64'd0);
    check("post-clr lane", 64'(rd_lane), 64'd1);
    check("post-clr pc", rd_pc, 64'h5004);

    // Randomized traffic, with one reset in the middle.
    for (int n = 0; n < 1500; n++) drive_rand(1);
    mid_reset();
    drive(1, 2'b01, 64'h6000, 64'h0, 32'h700, 32'h0, 0, 0);
    check("post-reset seq", 64'(rd_seq), 64'd0);
    for (int n = 0; n < 1500; n++) drive_rand(1);

    // Saturate the drop counter (and wrap the sequence counter).
    for (int n = 0; n < 33000; n++)
      drive(1, 2'b11, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom, $urandom, 0, 0);
    check("drop saturated", 64'(drop_cnt), 64'hFFFF);
    for (int n = 0; n < 500; n++) drive_rand(0);
    for (int n = 0; n < 500; n++) drive_rand(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
